// File: rtl/mini_core_pipe_ctrl.sv
// Pipeline sequencing controller for the mini_core 5-stage pipe: stage valids,
// per-stage flop enables, load-use bubbles, branch squash and memory-wait freeze.
module mini_core_pipe_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             Clock,
  input  logic             Rst,
  input  logic [4:0]       RegSrc1Q101H,
  input  logic [4:0]       RegSrc2Q101H,
  input  logic             Src1UsedQ101H,
  input  logic             Src2UsedQ101H,
  input  logic [4:0]       RegDstQ102H,
  input  logic             RegWrEnQ102H,
  input  logic             MemRdEnQ102H,
  input  logic             BranchOpQ102H,
  input  logic             BranchCondMetQ102H,
  input  logic             JumpQ102H,
  input  logic             DMemReqQ103H,
  input  logic             DMemAckQ103H,
  output logic             ReadyQ100H,
  output logic             ReadyQ101H,
  output logic             ReadyQ102H,
  output logic             ReadyQ103H,
  output logic             ReadyQ104H,
  output logic             ValidQ101H,
  output logic             ValidQ102H,
  output logic             ValidQ103H,
  output logic             ValidQ104H,
  output logic             SelNextPcAluOutQ102H,
  output logic             LoadUseStallQ101H,
  output logic             MemTimeoutErr,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_stall, redirect, load_use;
  logic              src1_hit, src2_hit;

  always_comb begin
    src1_hit   = Src1UsedQ101H & (RegSrc1Q101H == RegDstQ102H);
    src2_hit   = Src2UsedQ101H & (RegSrc2Q101H == RegDstQ102H);
    mem_stall  = ValidQ103H & DMemReqQ103H & ~DMemAckQ103H;
    redirect   = ValidQ102H & (JumpQ102H | (BranchOpQ102H & BranchCondMetQ102H));
    load_use   = ValidQ101H & ValidQ102H & MemRdEnQ102H & RegWrEnQ102H &
                 (RegDstQ102H != '0) & (src1_hit | src2_hit);
    state_next = mem_stall ? MEM_WAIT : RUN;

    ReadyQ100H           = 1'b1;
    ReadyQ101H           = 1'b1;
    ReadyQ102H           = 1'b1;
    ReadyQ103H           = 1'b1;
    ReadyQ104H           = 1'b1;
    SelNextPcAluOutQ102H = 1'b0;
    LoadUseStallQ101H    = 1'b0;

    if (!Rst) begin
      if (mem_stall) begin
        // Write-back still drains so the load in Q104H is not lost.
        ReadyQ100H = 1'b0;
        ReadyQ101H = 1'b0;
        ReadyQ102H = 1'b0;
        ReadyQ103H = 1'b0;
      end else if (redirect) begin
        SelNextPcAluOutQ102H = 1'b1;
      end else if (load_use) begin
        ReadyQ100H        = 1'b0;
        ReadyQ101H        = 1'b0;
        LoadUseStallQ101H = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Rst) begin
      state         <= RUN;
      ValidQ101H    <= 1'b0;
      ValidQ102H    <= 1'b0;
      ValidQ103H    <= 1'b0;
      ValidQ104H    <= 1'b0;
      StallCnt      <= '0;
      FlushCnt      <= '0;
      MemTimeoutErr <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      state <= state_next;

      if (mem_stall) begin
        ValidQ104H <= 1'b0;
      end else if (redirect) begin
        ValidQ101H <= 1'b0;
        ValidQ102H <= 1'b0;
        ValidQ103H <= 1'b1;
        ValidQ104H <= ValidQ103H;
      end else if (load_use) begin
        ValidQ102H <= 1'b0;
        ValidQ103H <= 1'b1;
        ValidQ104H <= ValidQ103H;
      end else begin
        ValidQ101H <= 1'b1;
        ValidQ102H <= ValidQ101H;
        ValidQ103H <= ValidQ102H;
        ValidQ104H <= ValidQ103H;
      end

      if (mem_stall | load_use)
        StallCnt <= StallCnt + CNT_W'(1);
      if (redirect & ~mem_stall)
        FlushCnt <= FlushCnt + CNT_W'(1);

      // Counts MEM_WAIT cycles; the error latches once the count reaches the limit.
      if (state == MEM_WAIT) begin
        if (wait_cnt != WAIT_MAX)
          wait_cnt <= wait_cnt + WAIT_W'(1);
        if (wait_cnt == WAIT_LAST)
          MemTimeoutErr <= 1'b1;
      end else if (mem_stall) begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/mini_core_pipe_ctrl.md
# mini_core_pipe_ctrl

Pipeline sequencing controller for the mini_core 5-stage pipeline (Q100H fetch, Q101H decode, Q102H execute, Q103H memory, Q104H write-back). It owns the per-stage valid bits and generates the flop enables (ReadyQ10xH) that the execute stage and its neighbours consume. It inserts a one-cycle bubble on load-use hazards, squashes wrong-path instructions on a taken branch or jump, and freezes the pipe while a data-memory access in Q103H is unacknowledged. It also keeps stall and flush counters and a sticky memory-timeout flag.

## Interface
- MEM_TIMEOUT, 64: wait cycles in MEM_WAIT after which MemTimeoutErr sets.
- CNT_W, 32: width of the StallCnt and FlushCnt counters.

- Clock  in  1  core clock; single clock domain.
- Rst  in  1  reset, synchronous, active-high.
- RegSrc1Q101H, RegSrc2Q101H  in  5 each  source registers of the instruction in decode.
- Src1UsedQ101H, Src2UsedQ101H  in  1 each  the decode instruction actually reads rs1 / rs2.
- RegDstQ102H  in  5  destination register of the instruction in execute.
- RegWrEnQ102H  in  1  the execute instruction writes a register.
- MemRdEnQ102H  in  1  the execute instruction is a load.
- BranchOpQ102H  in  1  the execute instruction is a conditional branch.
- BranchCondMetQ102H  in  1  branch condition from the ALU compare, same cycle.
- JumpQ102H  in  1  the execute instruction is JAL or JALR.
- DMemReqQ103H  in  1  the Q103H instruction issues a data-memory load or store.
- DMemAckQ103H  in  1  data memory accepts or completes the Q103H access this cycle.
- ReadyQ100H, ReadyQ101H, ReadyQ102H, ReadyQ103H, ReadyQ104H  out  1 each  enable for the PC register and for the flops capturing into each stage.
- ValidQ101H, ValidQ102H, ValidQ103H, ValidQ104H  out  1 each  registered stage-valid bits.
- SelNextPcAluOutQ102H  out  1  select AluOutQ102H as the next PC (redirect).
- LoadUseStallQ101H  out  1  a load-use bubble is inserted this cycle.
- MemTimeoutErr  out  1  sticky flag: memory wait reached MEM_TIMEOUT.
- StallCnt, FlushCnt  out  CNT_W each  free-running counters; wrap modulo 2^CNT_W.

## Operation
- State machine has two states.
  - RUN: normal flow.
  - MEM_WAIT: pipe frozen, waiting for the data-memory acknowledge.
- Qualified events, all combinational from the current cycle:
  - MemStall = ValidQ103H & DMemReqQ103H & !DMemAckQ103H.
  - Redirect = ValidQ102H & (JumpQ102H | (BranchOpQ102H & BranchCondMetQ102H)).
  - LoadUse = ValidQ101H & ValidQ102H & MemRdEnQ102H & RegWrEnQ102H & (RegDstQ102H != 0) & ((Src1UsedQ101H & RegSrc1Q101H == RegDstQ102H) | (Src2UsedQ101H & RegSrc2Q101H == RegDstQ102H)).
  - Redirect and LoadUse are mutually exclusive by construction: a branch or jump is never a load.
- Event priority: MemStall > Redirect > LoadUse.
- When MemStall is active:
  - ReadyQ100H through ReadyQ103H = 0; ReadyQ104H = 1.
  - ValidQ104H <= 0, ValidQ101H through ValidQ103H hold.
  - SelNextPcAluOutQ102H = 0.
  - The Redirect or LoadUse is not acted on this cycle. It re-evaluates once MemStall drops, because all Q101H/Q102H state is held.
- When Redirect is active (no MemStall):
  - All Ready = 1 and SelNextPcAluOutQ102H = 1.
  - ValidQ101H <= 0, ValidQ102H <= 0, ValidQ103H <= 1, ValidQ104H <= ValidQ103H.
  - FlushCnt increments.
- When LoadUse is active (no MemStall):
  - ReadyQ100H = ReadyQ101H = 0; ReadyQ102H through ReadyQ104H = 1.
  - ValidQ101H holds; ValidQ102H <= 0 (bubble); ValidQ103H <= 1; ValidQ104H <= ValidQ103H.
  - LoadUseStallQ101H = 1.
- Otherwise: all Ready = 1; ValidQ101H <= 1; ValidQ102H <= ValidQ101H; ValidQ103H <= ValidQ102H; ValidQ104H <= ValidQ103H.
- StallCnt increments every cycle in which MemStall or LoadUse is active.
- State transitions:
  - RUN -> MEM_WAIT when MemStall.
  - MEM_WAIT -> RUN on the cycle DMemAckQ103H = 1. That cycle behaves as the normal or Redirect/LoadUse case.
- Wait counter:
  - Cleared on entry to MEM_WAIT.
  - Increments each cycle spent in MEM_WAIT.
  - When it reaches MEM_TIMEOUT, MemTimeoutErr <= 1 and the counter saturates.
  - The controller keeps waiting after the error; the error clears only on Rst.

## Timing
- Ready*, SelNextPcAluOutQ102H and LoadUseStallQ101H are combinational from the current-cycle inputs and registered state. There are no register stages from the inputs to these outputs.
- Valid*, the state, the counters and MemTimeoutErr are registered and update on the rising edge of Clock.
- Reset values:
  - ValidQ101H through ValidQ104H = 0, state = RUN, StallCnt = FlushCnt = 0, MemTimeoutErr = 0.
  - During Rst, all Ready = 1 and SelNextPcAluOutQ102H = 0.
  - Rst asserted mid-stall or mid-flush overrides everything the next cycle.
- After Rst deasserts, ValidQ101H rises one cycle later, and each following stage valid rises one cycle after its predecessor.
- Load-use penalty: exactly 1 bubble. The dependent instruction enters Q102H while the load is in Q104H and takes forwarded RegWrDataQ104H.
- Taken branch or jump penalty: exactly 2 squashed slots.
- Memory-stall penalty: one frozen cycle per cycle with DMemAckQ103H = 0.

## Test plan
- Post-reset flow: release Rst with no hazards -> ValidQ101H..Q104H rise on consecutive cycles 1..4; all Ready = 1; counters stay 0.
- Load-use: lw x5 in Q102H, add x6,x5,x1 in Q101H -> one cycle with ReadyQ100H = ReadyQ101H = 0, LoadUseStallQ101H = 1, ValidQ102H = 0 next cycle; StallCnt = 1. Repeat with RegDstQ102H = 0 or Src1UsedQ101H = 0 -> no stall.
- Taken branch: BranchOpQ102H = 1, BranchCondMetQ102H = 1 -> SelNextPcAluOutQ102H = 1 that cycle; next cycle ValidQ101H = ValidQ102H = 0; FlushCnt = 1. Repeat with BranchCondMetQ102H = 0 -> no flush.
- Memory wait: DMemReqQ103H = 1 with DMemAckQ103H low for 3 cycles -> ReadyQ100H..Q103H = 0 for those 3 cycles, ValidQ104H = 0, StallCnt = 3; resume on the ack cycle.
- Priority collision: MemStall concurrent with a taken branch in Q102H -> no redirect while stalled; on the ack cycle SelNextPcAluOutQ102H = 1 and the flush occurs.
- Timeout: MEM_TIMEOUT = 4, ack withheld 10 cycles -> MemTimeoutErr = 1 from the 4th MEM_WAIT cycle, stays 1 after the ack, clears only on Rst.
